// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit.
// Captures an operand, op code and count on an accepted start, then moves the
// working value by up to STEP bit positions per cycle until the effective
// count is used up. The result, the last bit shifted out and an illegal-op
// flag are presented with a one-cycle done pulse and held until the next
// accepted start.
module shift_rotate_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int AW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             cout,
    output logic             op_err
);

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHRA = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    localparam logic [AW-1:0] WIDTH_AW = AW'(WIDTH);
    localparam logic [AW-1:0] STEP_AW  = AW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [AW-1:0]    r_rem;
    logic [WIDTH-1:0] r_data_out;
    logic             r_cout;
    logic             r_op_err;

    logic             w_accept;
    logic             w_op_legal;
    logic [AW-1:0]    w_k;
    logic [AW-1:0]    w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_work_next;
    logic             w_step_cout;
    logic [WIDTH:0]   w_shl_ext;
    logic [WIDTH:0]   w_shr_ext;
    logic [WIDTH:0]   w_sra_ext;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;

    // A start is only honoured when no operation is in flight.
    assign w_accept   = start && (r_state != S_RUN);
    assign w_op_legal = (op <= OP_ROR);

    // Effective count: rotates wrap modulo WIDTH, shifts saturate at WIDTH,
    // illegal ops complete immediately with the operand unchanged.
    always_comb begin
        w_k = '0;
        if (w_op_legal) begin
            if (op == OP_ROL || op == OP_ROR) begin
                w_k = {1'b0, amount[AW-2:0]};
            end else if (amount > WIDTH_AW) begin
                w_k = WIDTH_AW;
            end else begin
                w_k = amount;
            end
        end
    end

    // One RUN step: move by min(remaining, STEP); the extra guard bit of the
    // extended shifts catches the last bit leaving the word.
    always_comb begin
        w_step      = (r_rem < STEP_AW) ? r_rem : STEP_AW;
        w_shl_ext   = {1'b0, r_work} << w_step;
        w_shr_ext   = {r_work, 1'b0} >> w_step;
        w_sra_ext   = $signed({r_work, 1'b0}) >>> w_step;
        w_rol       = (r_work << w_step) | (r_work >> (WIDTH_AW - w_step));
        w_ror       = (r_work >> w_step) | (r_work << (WIDTH_AW - w_step));
        w_work_next = r_work;
        w_step_cout = 1'b0;
        case (r_op)
            OP_SHL:  {w_step_cout, w_work_next} = w_shl_ext;
            OP_SHR:  {w_work_next, w_step_cout} = w_shr_ext;
            OP_SHRA: {w_work_next, w_step_cout} = w_sra_ext;
            OP_ROL:  w_work_next = w_rol;
            OP_ROR:  w_work_next = w_ror;
            default: w_work_next = r_work;
        endcase
    end

    assign w_last = (r_rem == w_step);

    // State register; clr drops the unit straight back to IDLE.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: zero-count requests skip RUN, DONE lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_next = (w_k == '0) ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture, per-cycle stepping and result registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_op       <= '0;
            r_work     <= '0;
            r_rem      <= '0;
            r_data_out <= '0;
            r_cout     <= 1'b0;
            r_op_err   <= 1'b0;
        end else if (w_accept) begin
            r_op   <= op;
            r_work <= data_in;
            r_rem  <= w_k;
            if (w_k == '0) begin
                r_data_out <= data_in;
                r_cout     <= 1'b0;
                r_op_err   <= ~w_op_legal;
            end
        end else if (r_state == S_RUN) begin
            r_work <= w_work_next;
            r_rem  <= r_rem - w_step;
            if (w_last) begin
                r_data_out <= w_work_next;
                r_cout     <= w_step_cout;
                r_op_err   <= 1'b0;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign data_out = r_data_out;
    assign cout     = r_cout;
    assign op_err   = r_op_err;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench for shift_rotate_unit: one STEP=1 and one STEP=4
// instance, expected results queued at issue and popped at done.
module tb_shift_rotate_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        start1, start4;
    logic [2:0]  op;
    logic [31:0] din;
    logic [5:0]  amt;
    logic        busy1, done1, cout1, err1;
    logic        busy4, done4, cout4, err4;
    logic [31:0] dout1, dout4;

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic        e;
        int          k;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    shift_rotate_unit #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .clr(clr), .start(start1), .op(op), .data_in(din), .amount(amt),
        .busy(busy1), .done(done1), .data_out(dout1), .cout(cout1), .op_err(err1)
    );

    shift_rotate_unit #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .clr(clr), .start(start4), .op(op), .data_in(din), .amount(amt),
        .busy(busy4), .done(done4), .data_out(dout4), .cout(cout4), .op_err(err4)
    );

    // Bit-serial reference: one position per iteration.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] d, input logic [5:0] a);
        exp_t r;
        logic [31:0] v;
        logic c;
        int k;
        v = d; c = 1'b0; k = 0;
        if (o > 3'd4) begin
            r = '{d, 1'b0, 1'b1, 0};
            return r;
        end
        if (o == 3'd3 || o == 3'd4) k = int'(a) % 32;
        else k = (int'(a) > 32) ? 32 : int'(a);
        for (int i = 0; i < k; i++) begin
            case (o)
                3'd0: begin c = v[31]; v = {v[30:0], 1'b0}; end
                3'd1: begin c = v[0];  v = {1'b0, v[31:1]}; end
                3'd2: begin c = v[0];  v = {v[31], v[31:1]}; end
                3'd3: v = {v[30:0], v[31]};
                default: v = {v[0], v[31:1]};
            endcase
        end
        r = '{v, c, 1'b0, k};
        return r;
    endfunction

    // Issue one request and wait (bounded) for done; optionally pulse a
    // spurious start with scrambled operands after poke_at busy cycles.
    task automatic run_op(input bit sel4, input logic [2:0] o, input logic [31:0] d,
                          input logic [5:0] a, input int poke_at,
                          output int lat, output int nbusy, output logic [31:0] od,
                          output logic oc, output logic oe, output bit tmo);
        @(negedge clk);
        op = o; din = d; amt = a;
        if (sel4) start4 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        op = 3'($urandom); din = $urandom; amt = 6'($urandom);
        lat = 1; nbusy = 0; tmo = 1'b1; od = '0; oc = 1'b0; oe = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (sel4 ? done4 : done1) begin
                od = sel4 ? dout4 : dout1;
                oc = sel4 ? cout4 : cout1;
                oe = sel4 ? err4 : err1;
                tmo = 1'b0;
                break;
            end
            if (sel4 ? busy4 : busy1) nbusy++;
            start1 = !sel4 && poke_at > 0 && nbusy == poke_at && busy1;
            start4 = sel4 && poke_at > 0 && nbusy == poke_at && busy4;
            if (start1 || start4) begin
                op = 3'd4; din = $urandom; amt = 6'd5;
            end
            @(negedge clk);
            lat++;
        end
        start1 = 1'b0; start4 = 1'b0;
        $display("txn step=%0d op=%0d data=%h amt=%0d -> out=%h cout=%b err=%b busy=%0d lat=%0d",
                 sel4 ? 4 : 1, o, d, a, od, oc, oe, nbusy, lat);
    endtask

    task automatic test_reset();
        clr = 1'b0; start1 = 1'b0; start4 = 1'b0; op = '0; din = '0; amt = '0;
        @(negedge clk);
        total++;
        if ({busy1, done1, dout1, cout1, err1, busy4, done4, dout4, cout4, err4} !== '0)
            $display("FAIL reset_outputs got %h/%h want 0", dout1, dout4);
        else passed++;
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_rol();
        int lat, nb; logic [31:0] od; logic oc, oe; bit tmo; exp_t e;
        sb.push_back('{32'h0000_0003, 1'b0, 1'b0, 1});
        run_op(1'b0, 3'd3, 32'h8000_0001, 6'd1, 0, lat, nb, od, oc, oe, tmo);
        e = sb.pop_front();
        total++; if (tmo || od !== e.d) $display("FAIL rol_data got %h want %h", od, e.d); else passed++;
        total++; if (oc !== e.c || oe !== e.e) $display("FAIL rol_flags got %b%b want %b%b", oc, oe, e.c, e.e); else passed++;
        total++; if (nb != 1 || lat != 2) $display("FAIL rol_timing got busy=%0d lat=%0d want 1/2", nb, lat); else passed++;
    endtask

    task automatic test_shl_full();
        int lat, nb; logic [31:0] od; logic oc, oe; bit tmo; exp_t e;
        sb.push_back('{32'h0, 1'b1, 1'b0, 32});
        run_op(1'b0, 3'd0, 32'h0000_0001, 6'd32, 10, lat, nb, od, oc, oe, tmo);
        e = sb.pop_front();
        total++; if (tmo || od !== e.d) $display("FAIL shl32_data got %h want %h", od, e.d); else passed++;
        total++; if (oc !== e.c) $display("FAIL shl32_cout got %b want %b", oc, e.c); else passed++;
        total++; if (nb != 32) $display("FAIL shl32_busy got %0d want 32", nb); else passed++;
        @(negedge clk);
        total++; if (busy1 !== 1'b0 || done1 !== 1'b0) $display("FAIL shl32_poke_ignored got busy=%b done=%b want 0/0", busy1, done1); else passed++;
    endtask

    task automatic test_shra();
        int lat, nb; logic [31:0] od; logic oc, oe; bit tmo; exp_t e;
        sb.push_back('{32'hFFFF_FFFF, 1'b0, 1'b0, 31});
        run_op(1'b0, 3'd2, 32'h8000_0000, 6'd31, 0, lat, nb, od, oc, oe, tmo);
        e = sb.pop_front();
        total++; if (tmo || od !== e.d || oc !== e.c) $display("FAIL shra31 got %h/%b want %h/%b", od, oc, e.d, e.c); else passed++;
        total++; if (nb != 31) $display("FAIL shra31_busy got %0d want 31", nb); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e; int nb; bit seen;
        sb.push_back('{32'h0000_0003, 1'b0, 1'b0, 1});
        sb.push_back('{32'h0000_0001, 1'b0, 1'b0, 0});
        @(negedge clk);
        op = 3'd3; din = 32'h8000_0001; amt = 6'd33; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; din = $urandom; amt = 6'($urandom);
        nb = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (done1) begin seen = 1'b1; break; end
            if (busy1) nb++;
            @(negedge clk);
        end
        e = sb.pop_front();
        total++; if (!seen || dout1 !== e.d || nb != 1) $display("FAIL b2b_first got %h busy=%0d want %h busy=1", dout1, nb, e.d); else passed++;
        $display("txn step=1 op=3 amt=33 -> out=%h cout=%b", dout1, cout1);
        op = 3'd4; din = 32'h0000_0001; amt = 6'd0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; din = $urandom;
        e = sb.pop_front();
        total++; if (done1 !== 1'b1 || busy1 !== 1'b0) $display("FAIL b2b_second_done got done=%b busy=%b want 1/0", done1, busy1); else passed++;
        total++; if (dout1 !== e.d || cout1 !== e.c || err1 !== e.e) $display("FAIL b2b_second_data got %h/%b/%b want %h/%b/%b", dout1, cout1, err1, e.d, e.c, e.e); else passed++;
        $display("txn step=1 op=4 amt=0 -> out=%h cout=%b", dout1, cout1);
        @(negedge clk);
        total++; if (done1 !== 1'b0) $display("FAIL b2b_done_pulse got %b want 0", done1); else passed++;
    endtask

    task automatic test_step4();
        int lat, nb; logic [31:0] od; logic oc, oe; bit tmo; exp_t e;
        sb.push_back('{32'h7812_3456, 1'b0, 1'b0, 8});
        run_op(1'b1, 3'd4, 32'h1234_5678, 6'd8, 0, lat, nb, od, oc, oe, tmo);
        e = sb.pop_front();
        total++; if (tmo || od !== e.d || oc !== e.c) $display("FAIL ror4_data got %h/%b want %h/%b", od, oc, e.d, e.c); else passed++;
        total++; if (nb != 2) $display("FAIL ror4_busy got %0d want 2", nb); else passed++;
        sb.push_back('{32'hA5C3_0F96, 1'b0, 1'b1, 0});
        run_op(1'b1, 3'd7, 32'hA5C3_0F96, 6'd9, 0, lat, nb, od, oc, oe, tmo);
        e = sb.pop_front();
        total++; if (tmo || od !== e.d || oe !== e.e || oc !== e.c) $display("FAIL illegal_op got %h err=%b want %h err=%b", od, oe, e.d, e.e); else passed++;
        total++; if (nb != 0 || lat != 1) $display("FAIL illegal_timing got busy=%0d lat=%0d want 0/1", nb, lat); else passed++;
        repeat (3) @(negedge clk);
        total++; if (err4 !== 1'b1 || dout4 !== 32'hA5C3_0F96) $display("FAIL illegal_hold got %h err=%b want a5c30f96 err=1", dout4, err4); else passed++;
    endtask

    task automatic test_boundaries();
        logic [2:0] ops[4] = '{3'd1, 3'd2, 3'd0, 3'd2};
        logic [5:0] amts[4] = '{6'd40, 6'd32, 6'd63, 6'd0};
        int lat, nb; logic [31:0] od; logic oc, oe; bit tmo; exp_t e;
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 2; s++) begin
                sb.push_back(model(ops[i], 32'h8000_0001 ^ (i << 8), amts[i]));
                run_op(s == 1, ops[i], 32'h8000_0001 ^ (i << 8), amts[i], 0, lat, nb, od, oc, oe, tmo);
                e = sb.pop_front();
                total++; if (tmo || od !== e.d || oc !== e.c || oe !== e.e) $display("FAIL bound_%0d_s%0d got %h/%b/%b want %h/%b/%b", i, s, od, oc, oe, e.d, e.c, e.e); else passed++;
            end
        end
    endtask

    task automatic test_random(input int count);
        int lat, nb, stp; logic [31:0] d; logic [2:0] o; logic [5:0] a;
        logic [31:0] od; logic oc, oe; bit tmo; exp_t e;
        for (int i = 0; i < count; i++) begin
            bit s4;
            s4 = i[0];
            stp = s4 ? 4 : 1;
            o = 3'($urandom_range(0, 5)); d = $urandom; a = 6'($urandom_range(0, 63));
            sb.push_back(model(o, d, a));
            run_op(s4, o, d, a, 0, lat, nb, od, oc, oe, tmo);
            e = sb.pop_front();
            total++; if (tmo || od !== e.d || oc !== e.c || oe !== e.e) $display("FAIL rand_%0d got %h/%b/%b want %h/%b/%b", i, od, oc, oe, e.d, e.c, e.e); else passed++;
            total++; if (nb != (e.k + stp - 1) / stp) $display("FAIL rand_busy_%0d got %0d want %0d", i, nb, (e.k + stp - 1) / stp); else passed++;
        end
    endtask

    task automatic test_reset_abort();
        int dones; int lat, nb; logic [31:0] od; logic oc, oe; bit tmo; exp_t e;
        @(negedge clk);
        op = 3'd0; din = 32'h0000_0F0F; amt = 6'd20; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy1 !== 1'b1) $display("FAIL abort_busy_before got %b want 1", busy1); else passed++;
        clr = 1'b0;
        #1;
        total++; if ({busy1, done1, dout1, cout1, err1} !== '0) $display("FAIL abort_outputs got busy=%b done=%b out=%h cout=%b err=%b want 0", busy1, done1, dout1, cout1, err1); else passed++;
        @(negedge clk);
        clr = 1'b1;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done1 || busy1) dones++;
        end
        total++; if (dones != 0) $display("FAIL abort_no_done got %0d active cycles want 0", dones); else passed++;
        sb.push_back('{32'h0F00_0000, 1'b0, 1'b0, 4});
        run_op(1'b0, 3'd1, 32'hF000_0000, 6'd4, 0, lat, nb, od, oc, oe, tmo);
        e = sb.pop_front();
        total++; if (tmo || od !== e.d || oc !== e.c || nb != 4) $display("FAIL after_abort got %h/%b busy=%0d want %h/%b busy=4", od, oc, nb, e.d, e.c); else passed++;
    endtask

    initial begin
        test_reset();
        test_rol();
        test_shl_full();
        test_shra();
        test_back_to_back();
        test_step4();
        test_boundaries();
        test_random(24);
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_rotate_unit.md
SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; SHALL be a power of two, 8 to 64.
REQ-002 Parameter STEP, default 1: maximum bit positions moved per cycle; SHALL be a power of two, 1 to WIDTH.
REQ-003 Derived constant AW = log2(WIDTH)+1: amount width, able to express WIDTH itself.
REQ-004 Ports SHALL be as follows; one clock, and reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  3  000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR; 101-111 illegal.
- data_in  input  WIDTH  operand; captured with start.
- amount  input  AW  shift/rotate count; captured with start.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; data_out/cout valid.
- data_out  output  WIDTH  result; held until next accepted start.
- cout  output  1  last bit shifted out.
- op_err  output  1  illegal op flag; valid with done.

Function
REQ-005 FSM states SHALL be IDLE, RUN and DONE; done SHALL be high only in DONE, busy only in RUN.
REQ-006 start with clr high in IDLE or DONE SHALL be accepted at that edge (E0): op, data_in and the effective count k are captured; n = ceil(k/STEP).
REQ-007 k SHALL be amount mod WIDTH for ROL/ROR, and min(amount, WIDTH) for SHL/SHR/SHRA.
REQ-008 If n = 0, IDLE/DONE SHALL go to DONE at E0, with data_out = data_in and cout = 0.
REQ-009 If n > 0, the FSM SHALL enter RUN at E0.
REQ-010 Each RUN edge SHALL move the working value by min(remaining, STEP) positions; after n RUN edges (edge E0+n) the FSM SHALL enter DONE.
REQ-011 done SHALL therefore be high in the cycle after edge E0+n; latency = n+1 edges counting E0, busy high for exactly n cycles.
REQ-012 Per-op transforms:
- SHL: zero fill at the LSB.
- SHR: zero fill at the MSB.
- SHRA: replicate the original MSB.
- ROL/ROR: wrap the bits around.
REQ-013 For shift ops, cout SHALL be the last bit vacated (the final bit moved out of the word); for rotates, cout SHALL be 0.
REQ-014 A shift with k = WIDTH SHALL yield 0 for SHL/SHR and all-MSB for SHRA; cout SHALL follow REQ-013.
REQ-015 An illegal op SHALL behave as n = 0: data_out = data_in, done after E0, op_err = 1.
REQ-016 op_err SHALL be 0 for legal ops and SHALL be held with data_out.
REQ-017 start SHALL be ignored while busy; the operation in progress and the captured operands SHALL be unaffected.
REQ-018 DONE SHALL last one cycle, then go to IDLE; start in DONE SHALL be accepted per REQ-006, giving back-to-back operation.
REQ-019 Changes on op, data_in or amount outside the accepting edge SHALL have no effect.
REQ-020 Results SHALL be bit-exact with the combinational equivalent for all WIDTH/STEP legal values.

Reset
REQ-021 clr low SHALL immediately force state IDLE, busy = 0, done = 0, data_out = 0, cout = 0, op_err = 0 and the internal count = 0.
REQ-022 Reset during RUN SHALL abort the operation with no done pulse.
REQ-023 The first start accepted after clr rises SHALL behave per REQ-006.

Verification (WIDTH=32 unless stated)
REQ-024 STEP=1, ROL, 0x80000001, amount 1:
- data_out 0x00000003, cout 0.
- busy 1 cycle, done after E0+1.
REQ-025 STEP=1, SHL, 0x00000001, amount 32:
- data_out 0x00000000, cout 1.
- busy 32 cycles.
- A start pulsed at cycle 10 of RUN is ignored.
REQ-026 STEP=1, SHRA, 0x80000000, amount 31:
- data_out 0xFFFFFFFF, cout 0.
REQ-027 ROL, amount 33 (wraps to k=1), then in the DONE cycle a start with ROR, 0x00000001, amount 0:
- First result per REQ-024.
- Second result is data_out 0x00000001, done the next cycle, busy never high.
REQ-028 STEP=4, ROR, 0x12345678, amount 8:
- data_out 0x78123456, busy 2 cycles.
- Then op 111: data_out = data_in, op_err 1.
REQ-029 Reset abort: clr low at cycle 3 of an SHL-by-20:
- All outputs 0 immediately, no done pulse.
- After release, SHR 0xF0000000 by 4 gives 0x0F000000, cout 0.
